core_if_stage: RTL and testbench
================================

Name: core_if_stage

Overview:
Instruction fetch stage. It produces the 32-bit instruction word and PC consumed by the instruction decode stage. It owns the fetch PC and issues single-outstanding requests on the instruction bus (request/grant, then response valid). Control-flow redirects from execute flush it. Decode back-pressure stalls it.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
INSTR_NOP, 32'h0000_0013, word driven on o_instr when flushed, after reset, or on bus error (addi x0,x0,0)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_stall  input  1  decode cannot accept; instruction is consumed at an edge where o_instr_valid=1 and i_stall=0
i_redirect  input  1  one-cycle pulse from execute (taken branch, JAL, JALR)
i_redirect_pc  input  32  redirect target
o_bus_req  output  1  instruction bus request (combinational from state, o_instr_valid, i_stall)
o_bus_addr  output  32  request address, registered, word aligned
i_bus_gnt  input  1  request accepted in this cycle
i_bus_rvalid  input  1  response valid; at least 1 cycle after gnt
i_bus_rdata  input  32  response instruction word
i_bus_err  input  1  response error, qualified by i_bus_rvalid
o_instr  output  32  instruction to decode
o_pc  output  32  address of o_instr
o_instr_valid  output  1  o_instr/o_pc hold an unconsumed instruction
o_fault  output  1  current o_instr came from an errored response; valid only with o_instr_valid

Behaviour:
- Reset (i_rst=1 at an edge): state=IDLE, fetch_pc=o_bus_addr=RESET_PC, o_instr=INSTR_NOP, o_pc=RESET_PC, o_instr_valid=0, o_fault=0, discard=0. Reset overrides every other input.
- Internal regs: fetch_pc (drives o_bus_addr), req_pc (address of outstanding request), discard flag.
- FSM states and transitions:
  - IDLE: o_bus_req=0. Next state REQ unconditionally. One cycle after reset only.
  - REQ: o_bus_req = !o_instr_valid || !i_stall. This guarantees the output register is free when the response lands.
    - On o_bus_req && i_bus_gnt: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps mod 2^32), go to WAIT.
    - Otherwise stay in REQ. o_bus_addr holds stable while req is high without gnt.
  - WAIT: o_bus_req=0.
    - On i_bus_rvalid with discard=1: drop the data, discard<=0, go to REQ.
    - On i_bus_rvalid with discard=0: o_instr<=(i_bus_err ? INSTR_NOP : i_bus_rdata), o_pc<=req_pc, o_fault<=i_bus_err, o_instr_valid<=1, go to REQ.
- i_bus_rvalid in IDLE or REQ is ignored, including a stale response after reset mid-WAIT.
- Consumption: at an edge with o_instr_valid && !i_stall and no new load, o_instr_valid<=0. o_instr and o_pc hold their values.
- Back-to-back loads: a load in the same cycle as consumption keeps o_instr_valid=1 with the new data.
- Throughput: one instruction per 2 cycles at best (gnt in REQ, rvalid next cycle in WAIT). No PC prediction.
- Redirect (i_redirect=1 at an edge) overrides stall and load:
  - fetch_pc<={i_redirect_pc[31:2],2'b00}.
  - o_instr_valid<=0, o_instr<=INSTR_NOP, o_fault<=0.
  - In WAIT without rvalid in this cycle: discard<=1, stay in WAIT.
  - In WAIT with rvalid in this cycle: the response is dropped, discard stays 0, go to REQ.
  - In REQ with gnt in this cycle: the granted request is for the old path. Go to WAIT with discard<=1; fetch_pc takes the redirect target, not +4.
  - In REQ without gnt: stay in REQ. The new address is presented the next cycle.
  - Redirect in IDLE: fetch_pc is updated; go to REQ.
- o_bus_addr in the redirect cycle is still the old fetch_pc; there is no combinational bypass of i_redirect_pc.
- Redirect targets with bits [1:0] != 0 are silently aligned. Misalignment is reported by execute, not here.
- Redirect while a discard is already pending: only one response is outstanding, so discard stays 1.

Test Plan:
- Reset, bus gnt same cycle, rvalid 1 cycle later, rdata 0x00500093, i_stall=0: o_bus_addr=0,4,8 in sequence; o_instr=0x00500093 with o_pc=0 and o_instr_valid=1 at cycle 3; o_bus_req low in IDLE cycle.
- i_stall=1 while o_instr_valid=1 with o_pc=0x4: o_bus_req=0, o_instr/o_pc held 0x4 for 5 cycles; release stall -> consumed, next fetch at 0x8 issued in the same cycle.
- Redirect to 0x100 in WAIT, rvalid 3 cycles later with 0xDEADBEEF: response dropped, o_instr_valid stays 0, next request addr=0x100, its response shown with o_pc=0x100.
- Redirect to 0x202 coincident with gnt in REQ: o_bus_addr=0x200 next request, stale response discarded; redirect coincident with rvalid: data dropped, no discard pending (next rvalid accepted).
- i_bus_rvalid with i_bus_err=1: o_instr=0x00000013, o_fault=1, o_instr_valid=1, o_pc=req_pc; next good response clears o_fault.
- Reset asserted mid-WAIT, late rvalid arrives in IDLE: ignored, first request at RESET_PC; fetch_pc 0xFFFFFFFC increments to 0x00000000.

Source files
------------

// File: rtl/core_if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding requests on the
// instruction bus and holds one fetched instruction for decode.
module core_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] INSTR_NOP = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_err,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_instr_valid,
  output logic        o_fault
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0] r_req_pc, w_req_pc_nxt;
  logic        r_discard, w_discard_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_fault, w_fault_nxt;

  logic        w_req;
  logic        w_load;
  logic [31:0] w_target;

  // Only request when the output register is guaranteed free by the time data returns.
  assign w_req    = (r_state == StReq) && (!r_valid || !i_stall);
  assign w_load   = (r_state == StWait) && i_bus_rvalid && !r_discard && !i_redirect;
  assign w_target = i_redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_discard_nxt  = r_discard;
    unique case (r_state)
      StIdle: begin
        w_state_nxt = StReq;
        if (i_redirect) w_fetch_pc_nxt = w_target;
      end
      StReq: begin
        if (w_req && i_bus_gnt) begin
          w_req_pc_nxt   = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_state_nxt    = StWait;
          // Granted request belongs to the old path; drop its response.
          if (i_redirect) w_discard_nxt = 1'b1;
        end
        if (i_redirect) w_fetch_pc_nxt = w_target;
      end
      StWait: begin
        if (i_bus_rvalid) begin
          w_discard_nxt = 1'b0;
          w_state_nxt   = StReq;
        end else if (i_redirect) begin
          w_discard_nxt = 1'b1;
        end
        if (i_redirect) w_fetch_pc_nxt = w_target;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_instr_nxt = r_instr;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_fault_nxt = r_fault;
    if (i_redirect) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = INSTR_NOP;
      w_fault_nxt = 1'b0;
    end else if (w_load) begin
      w_instr_nxt = i_bus_err ? INSTR_NOP : i_bus_rdata;
      w_pc_nxt    = r_req_pc;
      w_fault_nxt = i_bus_err;
      w_valid_nxt = 1'b1;
    end else if (r_valid && !i_stall) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_discard  <= 1'b0;
      r_instr    <= INSTR_NOP;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_discard  <= w_discard_nxt;
      r_instr    <= w_instr_nxt;
      r_pc       <= w_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  assign o_bus_req     = w_req;
  assign o_bus_addr    = r_fetch_pc;
  assign o_instr       = r_instr;
  assign o_pc          = r_pc;
  assign o_instr_valid = r_valid;
  assign o_fault       = r_fault;

endmodule

// File: tb/tb_core_if_stage.sv
// Cycle-table bench for core_if_stage: each row gives the inputs for one cycle and the
// outputs expected during that cycle (before its rising edge).
module tb_core_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        err = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ivalid;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_if_stage dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_redirect   (redir),
    .i_redirect_pc(redir_pc),
    .o_bus_req    (bus_req),
    .o_bus_addr   (bus_addr),
    .i_bus_gnt    (gnt),
    .i_bus_rvalid (rvalid),
    .i_bus_rdata  (rdata),
    .i_bus_err    (err),
    .o_instr      (instr),
    .o_pc         (pc),
    .o_instr_valid(ivalid),
    .o_fault      (fault)
  );

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        chk;
    logic        e_req;
    logic [31:0] e_addr, e_instr, e_pc;
    logic        e_valid, e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] rpc, logic g,
                              logic rv, logic [31:0] dat, logic e, logic c, logic xreq,
                              logic [31:0] xaddr, logic [31:0] xinstr, logic [31:0] xpc,
                              logic xvalid, logic xfault);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd; v.rpc = rpc; v.gnt = g; v.rvalid = rv;
    v.rdata = dat; v.err = e; v.chk = c; v.e_req = xreq; v.e_addr = xaddr;
    v.e_instr = xinstr; v.e_pc = xpc; v.e_valid = xvalid; v.e_fault = xfault;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int row);
    @(negedge clk);
    rst = v.rst; stall = v.stall; redir = v.redir; redir_pc = v.rpc;
    gnt = v.gnt; rvalid = v.rvalid; rdata = v.rdata; err = v.err;
    #1;
    if (v.chk) begin
      check("bus_req", row, {31'd0, bus_req}, {31'd0, v.e_req});
      check("bus_addr", row, bus_addr, v.e_addr);
      check("instr_valid", row, {31'd0, ivalid}, {31'd0, v.e_valid});
      check("instr", row, instr, v.e_instr);
      check("pc", row, pc, v.e_pc);
      if (v.e_valid) check("fault", row, {31'd0, fault}, {31'd0, v.e_fault});
    end
  endtask

  initial begin
    // rst stall redir rpc gnt rvalid rdata err | chk req addr instr pc valid fault
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, NOP, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, NOP, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00500093, 0, 1, 0, 4, NOP, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 4, 32'h00500093, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00100113, 0, 1, 0, 8, 32'h00500093, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 8, 32'h00100113, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 8, 32'h00100113, 4, 1, 0));
    // Redirect in WAIT, stale response three cycles later.
    vecs.push_back(mk(0, 0, 1, 32'h100, 1, 0, 0, 0, 1, 0, 32'hC, 32'h00100113, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h100, NOP, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h100, NOP, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 1, 0, 32'h100, NOP, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h100, NOP, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00A00513, 0, 1, 0, 32'h104, NOP, 4, 0, 0));
    // Redirect coincident with gnt.
    vecs.push_back(mk(0, 0, 1, 32'h202, 1, 0, 0, 0, 1, 1, 32'h104, 32'h00A00513, 32'h100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h11111111, 0, 1, 0, 32'h200, NOP, 32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h200, NOP, 32'h100, 0, 0));
    // Redirect coincident with rvalid.
    vecs.push_back(mk(0, 0, 1, 32'h300, 1, 1, 32'h22222222, 0, 1, 0, 32'h204, NOP, 32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h300, NOP, 32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h33333333, 0, 1, 0, 32'h304, NOP, 32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h304, 32'h33333333, 32'h300, 1, 0));
    // Bus error, then a good response clears the fault.
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h44444444, 1, 1, 0, 32'h308, 32'h33333333, 32'h300, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h308, NOP, 32'h304, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h55555555, 0, 1, 0, 32'h30C, NOP, 32'h304, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h30C, 32'h55555555, 32'h308, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h30C, 32'h55555555, 32'h308, 0, 0));
    // Reset mid-WAIT, late rvalid in IDLE and REQ must be ignored.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h310, 32'h55555555, 32'h308, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h66666666, 0, 1, 0, 0, NOP, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h66666666, 0, 1, 1, 0, NOP, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h77777777, 0, 1, 0, 4, NOP, 0, 0, 0));
    // Misaligned redirect near the top of memory, then wrap to 0.
    vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFD, 0, 0, 0, 0, 1, 1, 4, 32'h77777777, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'hFFFFFFFC, NOP, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h88888888, 0, 1, 0, 0, NOP, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h88888888, 32'hFFFFFFFC, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h88888888, 32'hFFFFFFFC, 1, 0));

    foreach (vecs[i]) step(vecs[i], i);

    // Redirect while a discard is already pending: discard must survive the second one.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 100);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NOP, 0, 0, 0), 101);
    begin
      bit granted = 1'b0;
      for (int c = 0; c < 8 && !granted; c++) begin
        @(negedge clk);
        gnt = 1'b1;
        #1;
        if (bus_req) granted = 1'b1;
      end
      check("req_seen", 102, {31'd0, granted}, 32'd1);
      check("req_addr", 102, bus_addr, 32'h0);
    end
    step(mk(0, 0, 1, 32'h400, 0, 0, 0, 0, 1, 0, 4, NOP, 0, 0, 0), 103);
    step(mk(0, 0, 1, 32'h503, 0, 0, 0, 0, 1, 0, 32'h400, NOP, 0, 0, 0), 104);
    step(mk(0, 0, 0, 0, 0, 1, 32'h99999999, 0, 1, 0, 32'h500, NOP, 0, 0, 0), 105);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h500, NOP, 0, 0, 0), 106);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
